// File: rtl/fft_magnitude.sv
// ---------------------------------------------------------------------------
// fft_magnitude
//
// Converts a block of complex FFT bins into unsigned magnitude "bars" using
// the alpha-max-plus-beta-min approximation:
//     mag = max(|re|,|im|) + min(|re|,|im|)/4 + min(|re|,|im|)/8
//
// A conversion is started with a four-phase start/done handshake. On the
// start edge the whole input block is snapshotted, then one bin is
// processed per clock into a shadow array. The visible bars update all at
// once on the edge that processes the last bin, so downstream logic never
// sees a half-updated frame.
//
// Parameters
//   NBINS  number of frequency bins
//   W      width of each real/imag component and of each magnitude
//
// Ports
//   clk    clock, all logic on the rising edge
//   rst    synchronous active-high reset
//   start  handshake request level
//   freqs  per-bin {re, im}, two's complement, re in [2W-1:W]
//   bars   per-bin unsigned magnitude, registered
//   done   handshake acknowledge, registered
//   busy   high while a conversion is in progress, registered
// ---------------------------------------------------------------------------
module fft_magnitude #(
    parameter int NBINS = 16,
    parameter int W     = 18
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NBINS-1:0][2*W-1:0]     freqs,
    output logic [NBINS-1:0][W-1:0]       bars,
    output logic                          done,
    output logic                          busy
);

    localparam int IW = (NBINS > 1) ? $clog2(NBINS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBINS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t              state_reg;
    logic [IW-1:0]       idx_reg;
    logic                done_reg;
    logic                busy_reg;

    // Snapshot of the input block, gathered from the per-bin registers
    logic [NBINS-1:0][2*W-1:0] snap_bus;

    // Control strobes shared by every bin slice
    logic snap_en;
    logic calc_en;
    logic commit_en;

    assign snap_en   = (state_reg == IDLE) && start;
    assign calc_en   = (state_reg == CALC);
    assign commit_en = calc_en && (idx_reg == LAST_IDX);

    // -----------------------------------------------------------------------
    // Magnitude datapath for the bin currently addressed by idx_reg
    // -----------------------------------------------------------------------
    logic [2*W-1:0] cur_bin;
    logic [W-1:0]   re_val;
    logic [W-1:0]   im_val;
    logic [W-1:0]   re_abs;
    logic [W-1:0]   im_abs;
    logic [W-1:0]   mx;
    logic [W-1:0]   mn;
    logic [W-1:0]   mag_next;

    always_comb begin
        cur_bin = snap_bus[idx_reg];
        re_val  = cur_bin[2*W-1:W];
        im_val  = cur_bin[W-1:0];
        // Negating the most negative value wraps back to 2^(W-1), which is
        // exactly the right unsigned magnitude, so no special case is needed.
        re_abs  = re_val[W-1] ? (~re_val + W'(1)) : re_val;
        im_abs  = im_val[W-1] ? (~im_val + W'(1)) : im_val;
        if (re_abs >= im_abs) begin
            mx = re_abs;
            mn = im_abs;
        end else begin
            mx = im_abs;
            mn = re_abs;
        end
        // Worst case is 1.375 * 2^(W-1) < 2^W, so the sum cannot overflow W bits
        mag_next = mx + (mn >> 2) + (mn >> 3);
    end

    // -----------------------------------------------------------------------
    // Per-bin storage: snapshot, shadow result and visible bar
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
            logic [2*W-1:0] snap_reg;
            logic [W-1:0]   shadow_reg;
            logic [W-1:0]   bars_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    snap_reg   <= '0;
                    shadow_reg <= '0;
                    bars_reg   <= '0;
                end else begin
                    if (snap_en) begin
                        snap_reg <= freqs[gi];
                    end
                    if (calc_en && (idx_reg == IW'(gi))) begin
                        shadow_reg <= mag_next;
                    end
                    // The last bin's result is still in flight on the commit
                    // edge, so it bypasses the shadow and goes straight out.
                    if (commit_en) begin
                        bars_reg <= (gi == NBINS - 1) ? mag_next : shadow_reg;
                    end
                end
            end

            assign snap_bus[gi] = snap_reg;
            assign bars[gi]     = bars_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= CALC;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                CALC: begin
                    // start is deliberately ignored here
                    if (idx_reg == LAST_IDX) begin
                        state_reg <= DONE;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end
                DONE: begin
                    // Wait for the requester to drop start before re-arming
                    if (!start) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign done = done_reg;
    assign busy = busy_reg;

endmodule

// File: doc/fft_magnitude.md
FFT_MAGNITUDE -- requirements
Module: fft_magnitude

Interface
REQ-001 SHALL have parameter NBINS, default 16, giving the number of frequency bins.
REQ-002 SHALL have parameter W, default 18, giving the per-component and per-magnitude width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request level, part of a four-phase start/done handshake.
REQ-006 SHALL have port freqs  input  NBINS x 2W  per-bin data: real part in [2W-1:W], imaginary part in [W-1:0], both two's-complement.
REQ-007 SHALL have port bars  output  NBINS x W  unsigned magnitude per bin, registered.
REQ-008 SHALL have port done  output  1  handshake acknowledge, registered.
REQ-009 SHALL have port busy  output  1  high while a conversion is in progress, registered.

Function
REQ-010 SHALL implement states IDLE, CALC and DONE.
REQ-011 IDLE with start=1 sampled SHALL, at that edge (E0), snapshot all of freqs into internal registers, clear the bin index to 0, set busy=1 and go to CALC.
REQ-012 CALC SHALL process exactly one bin per edge, in bin order 0..NBINS-1, using only the snapshot; changes on freqs after E0 SHALL NOT affect the results.
REQ-013 Per-bin arithmetic SHALL be: a=|re|, b=|im| as W-bit unsigned; mx=max(a,b), mn=min(a,b); mag = mx + (mn>>2) + (mn>>3), truncating shifts.
REQ-014 |-2^(W-1)| SHALL equal 2^(W-1) with no overflow; the maximum mag is 180224 for W=18, which fits in W bits, so no saturation is required.
REQ-015 Results SHALL accumulate in a shadow array; bars SHALL keep their previous values throughout CALC.
REQ-016 At the edge processing bin NBINS-1 (E16 for the default configuration), all NBINS bars SHALL update atomically from the shadow (including that last bin), busy SHALL go to 0, done SHALL go to 1, and the state SHALL become DONE.
REQ-017 Latency from the start-sampling edge to done high SHALL be NBINS edges.
REQ-018 DONE SHALL hold done=1 while start=1; at the first edge with start=0, it SHALL clear done and go to IDLE.
REQ-019 If start is already 0 on entry to DONE, done SHALL be high for exactly one cycle.
REQ-020 Holding start high SHALL NOT start a second conversion; a new run requires start low in DONE, then high in IDLE.
REQ-021 start asserted or toggled during CALC SHALL be ignored.
REQ-022 done and busy SHALL never be high simultaneously.

Reset
REQ-023 rst=1 at any edge, including mid-CALC or in DONE, SHALL force state IDLE, bin index 0, busy=0, done=0, all bars=0, and the shadow array to 0.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 The first edge with rst=0 and start=1 SHALL begin a normal conversion.

Verification
REQ-026 Reset: apply rst for 2 cycles -> bars all 0, done=0, busy=0, state IDLE.
REQ-027 Arithmetic:
  - bin0 re=3000, im=-4000 -> bars[0]=5125.
  - bin1 re=-131072, im=0 -> 131072.
  - bin2 re=im=-131072 -> 180224.
  - other bins 0 -> 0.
  - done rises exactly 16 edges after start is sampled.
REQ-028 Handshake: hold start high for 40 cycles -> done stays high until start drops, then falls 1 edge later; busy pulses only once; no second run.
REQ-029 Snapshot: change freqs and pulse start at CALC cycle 5 -> results reflect the E0 values; the run is not restarted; bars are unchanged until E16.
REQ-030 Reset mid-operation: assert rst at CALC cycle 8 -> bars=0, busy=0, done=0; the next start yields correct results with 16-edge latency.
